design_switch_sequencer: RTL and testbench

- Wishbone-configured controller that decides which hosted design owns the shared pad/clock resources.
- Sequences a safe hand-over between designs: reset the old design, then gate the clock, then switch the select, then reset the new design, then release.
- Generates the divided design clock enable and the per-design resets consumed by the pad multiplexer.
- Sits between the management Wishbone bus and the multiplexer. It replaces ad-hoc direct register writes to the select.

---
 rtl/design_switch_sequencer.sv | 153 +++++++++++++++
 tb/tb_design_switch_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/design_switch_sequencer.sv
// Decides which hosted design owns the shared pads/clock; sequences reset-old, clock gap, select, reset-new.
// Wishbone acks one cycle after a hit with no wait states; a held strobe acks every other cycle.
module design_switch_sequencer #(
    parameter int          NUM_DESIGNS = 13,
    parameter int          RST_CYCLES  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic [31:0]            wbs_dat_o,
    output logic                   wbs_ack_o,
    output logic [3:0]             sel_o,
    output logic [NUM_DESIGNS-1:0] rst_o,
    output logic                   clk_en_o,
    output logic                   busy_o
);
    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_RST_OLD = 2'd1,
        S_GAP     = 2'd2,
        S_RST_NEW = 2'd3
    } state_t;

    localparam int                   CW      = $clog2(RST_CYCLES + 1);
    localparam logic [CW-1:0]        LAST    = CW'(RST_CYCLES - 1);
    localparam logic [NUM_DESIGNS-1:0] ONE   = NUM_DESIGNS'(1);
    localparam logic [4:0]           ND5     = 5'(NUM_DESIGNS);

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [3:0]             r_sel;
    logic [3:0]             r_pend;
    logic [7:0]             r_div;
    logic [7:0]             r_dcnt;
    logic                   r_err;
    logic                   r_ack;
    logic [31:0]            r_dat;
    logic [NUM_DESIGNS-1:0] r_rst;

    logic        w_acc, w_wr, w_rd;
    logic [1:0]  w_reg;
    logic        w_sel_wr, w_sel_ok, w_sel_bad, w_div_wr, w_st_rd;
    logic        w_tick, w_en;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Blocking accept while ack is high gives the one-cycle ack and the alternate-cycle held strobe.
    assign w_acc     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~r_ack;
    assign w_wr      = w_acc & wbs_we_i;
    assign w_rd      = w_acc & ~wbs_we_i;
    assign w_reg     = wbs_adr_i[3:2];
    assign w_sel_wr  = w_wr & (w_reg == 2'd0);
    assign w_sel_ok  = w_sel_wr & (r_state == S_RUN) & ({1'b0, wbs_dat_i[3:0]} < ND5);
    assign w_sel_bad = w_sel_wr & ~w_sel_ok;
    assign w_div_wr  = w_wr & (w_reg == 2'd1);
    assign w_st_rd   = w_rd & (w_reg == 2'd2);
    assign w_unused  = ^{wbs_dat_i[31:8], wbs_adr_i[1:0]};

    assign w_tick    = (r_dcnt == r_div);
    assign w_en      = w_tick & (r_state != S_GAP) & ~rst;

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            2'd0:    w_rdata = {28'b0, r_sel};
            2'd1:    w_rdata = {24'b0, r_div};
            2'd2:    w_rdata = {24'b0, 1'b0, r_state, r_err, r_sel};
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack  <= 1'b0;
            r_dat  <= '0;
            r_div  <= '0;
            r_dcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_ack <= w_acc;
            r_dat <= w_rd ? w_rdata : 32'b0;
            // A new error wins over the clear-on-read in the same cycle.
            r_err <= (r_err & ~w_st_rd) | w_sel_bad;
            if (w_div_wr) begin
                r_div  <= wbs_dat_i[7:0];
                r_dcnt <= '0;
            end else if (w_tick) begin
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RST_NEW;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_pend  <= '0;
            r_rst   <= '1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_sel_ok) begin
                        r_pend  <= wbs_dat_i[3:0];
                        r_cnt   <= '0;
                        r_rst   <= '1;
                        r_state <= S_RST_OLD;
                    end
                end
                S_RST_OLD: begin
                    if (w_en) begin
                        if (r_cnt == LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_GAP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    r_sel   <= r_pend;
                    r_cnt   <= '0;
                    r_state <= S_RST_NEW;
                end
                default: begin
                    if (w_en) begin
                        if (r_cnt == LAST) begin
                            r_cnt   <= '0;
                            r_rst   <= ~(ONE << r_sel);
                            r_state <= S_RUN;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign sel_o     = r_sel;
    assign rst_o     = r_rst;
    assign clk_en_o  = w_en;
    assign busy_o    = (r_state != S_RUN);
endmodule

// File: tb/tb_design_switch_sequencer.sv
// Directed bench for design_switch_sequencer; bus read data is checked by a scoreboard monitor.
module tb_design_switch_sequencer;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, wdat = '0;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic [3:0]  sel_o;
    logic [12:0] rst_o;
    logic        clk_en_o, busy_o;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] exp_q[$];
    logic        seen5 = 1'b0;

    design_switch_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .sel_o     (sel_o),
        .rst_o     (rst_o),
        .clk_en_o  (clk_en_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: every ack pops one expected data word.
    always @(negedge clk) begin
        if (sel_o == 4'd5) seen5 = 1'b1;
        if (wbs_ack_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ack: got ack with data 0x%0h, expected no ack", wbs_dat_o);
            end else begin
                check("wb_rdata", wbs_dat_o, exp_q.pop_front());
            end
        end
    end

    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; samples once per cycle until busy_o drops.
    task automatic run_phase(input string tag, input logic [3:0] tgt,
                             input int e_busy, input int e_en, input int e_sel);
        int b, en, s, bad;
        b = 0; en = 0; s = -1; bad = 0;
        while (busy_o && b < 1000) begin
            if (clk_en_o) en++;
            if (s < 0 && sel_o == tgt) s = b;
            if (rst_o != 13'h1FFF) bad++;
            b++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, b, e_busy);
        check({tag, "_en_pulses"}, en, e_en);
        check({tag, "_sel_cycle"}, s, e_sel);
        check({tag, "_rst_held"}, bad, 0);
    endtask

    initial begin
        logic [7:0] pat;
        logic [5:0] ack_pat;
        int         acks;

        // Power-up
        repeat (3) @(negedge clk);
        check("rst_ack", wbs_ack_o, 0);
        check("rst_dat", wbs_dat_o, 0);
        check("rst_clk_en", clk_en_o, 0);
        check("rst_sel", sel_o, 0);
        check("rst_rsto", rst_o, 13'h1FFF);
        check("rst_busy", busy_o, 1);
        rst = 1'b0;
        #1;
        run_phase("powerup", 4'd0, 8, 8, 0);
        check("powerup_rsto", rst_o, 13'h1FFE);
        wb_xfer(0, BASE + 32'h8, 0, 32'h000);
        wb_xfer(0, BASE + 32'h0, 0, 32'h000);
        wb_xfer(0, BASE + 32'h4, 0, 32'h000);

        // Switch to design 9
        wb_xfer(1, BASE, 32'd9, 0);
        run_phase("sel9", 4'd9, 17, 16, 9);
        check("sel9_rsto", rst_o, 13'h1DFF);
        wb_xfer(0, BASE + 32'h8, 0, 32'h009);

        // Out-of-range index
        wb_xfer(1, BASE, 32'd13, 0);
        check("sel13_sel", sel_o, 9);
        wb_xfer(0, BASE + 32'h8, 0, 32'h019);
        wb_xfer(0, BASE + 32'h8, 0, 32'h009);

        // Write while busy, then STATUS during RST_OLD
        wb_xfer(1, BASE, 32'd4, 0);
        wb_xfer(1, BASE, 32'd2, 0);
        wb_xfer(0, BASE + 32'h8, 0, 32'h039);
        run_phase("sel4", 4'd4, 13, 12, 5);
        check("sel4_rsto", rst_o, 13'h1FEF);
        wb_xfer(0, BASE + 32'h8, 0, 32'h004);

        // Held strobe on STATUS
        repeat (3) exp_q.push_back(32'h004);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h8;
        ack_pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ack_pat[i] = wbs_ack_o;
        end
        stb = 1'b0; cyc = 1'b0;
        check("held_stb_acks", {26'b0, ack_pat}, 32'h15);

        // Outside the window
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 32'h10; wdat = 32'd1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acks += int'(wbs_ack_o);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        check("nohit_acks", acks, 0);
        check("nohit_sel", sel_o, 4);

        // Reserved offset
        wb_xfer(0, BASE + 32'hC, 0, 32'h0);
        wb_xfer(1, BASE + 32'hC, 32'hFFFF_FFFF, 32'h0);
        wb_xfer(0, BASE, 0, 32'h4);

        // Divider
        wb_xfer(1, BASE + 32'h4, 32'd3, 0);
        pat = '0;
        for (int i = 0; i < 8; i++) begin
            pat[i] = clk_en_o;
            @(negedge clk);
        end
        check("div3_pattern", {24'b0, pat}, 32'h88);
        wb_xfer(1, BASE, 32'd7, 0);
        run_phase("sel7_div3", 4'd7, 62, 16, 31);
        check("sel7_rsto", rst_o, 13'h1F7F);
        wb_xfer(0, BASE + 32'h4, 0, 32'h3);

        // Reset during RST_OLD
        wb_xfer(1, BASE, 32'd5, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_clk_en", clk_en_o, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_sel", sel_o, 0);
        check("midrst_rsto", rst_o, 13'h1FFF);
        run_phase("midrst", 4'd0, 8, 8, 0);
        check("midrst_final_rsto", rst_o, 13'h1FFE);
        wb_xfer(0, BASE + 32'h8, 0, 32'h000);

        // Re-selecting the active design restarts it
        wb_xfer(1, BASE, 32'd0, 0);
        run_phase("resel0", 4'd0, 17, 16, 0);
        check("resel0_rsto", rst_o, 13'h1FFE);

        repeat (2) @(negedge clk);
        check("never_sel5", seen5, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion, expected finish within 200000 time units");
        $fatal(1);
    end
endmodule
